// File: rtl/fdc_pkg.sv
// Shared types, default parameters and the saturating increment used by fdc_meter.
package fdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } fdc_state_e;

  localparam int NCH_DEF         = 2;
  localparam int CNT_W_DEF       = 16;
  localparam int GATE_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // Working width of sat_inc; counters up to this width are supported.
  localparam int SAT_W = 64;

  // Increment that sticks at max_val. Callers can detect saturation by
  // comparing the returned value with the input.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] cnt,
                                               input logic [SAT_W-1:0] max_val);
    if (cnt >= max_val) begin
      return max_val;
    end
    return cnt + SAT_W'(1);
  endfunction

endpackage

// File: rtl/fdc_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus a rising-edge detector.
module fdc_sync_edge
  import fdc_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Shift the pin through the synchroniser and keep the previous synced level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // One-clk pulse on the first cycle the synced level is seen high.
  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/fdc_meter.sv
// Frequency-to-digital converter: counts rising edges of one selected VCO
// input over a programmable number of reference periods and publishes a
// saturating count with a valid strobe. Single-shot or back-to-back windows.
module fdc_meter
  import fdc_pkg::*;
#(
  parameter  int NCH         = NCH_DEF,
  parameter  int CNT_W       = CNT_W_DEF,
  parameter  int GATE_W      = GATE_W_DEF,
  parameter  int SYNC_STAGES = SYNC_STAGES_DEF,
  localparam int SEL_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    vco_in,
  input  logic              ref_in,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              cont,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic              result_valid,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fdc_state_e        state, state_nxt;
  logic              load_sh;
  logic [SEL_W-1:0]  ch_sh;
  logic [GATE_W-1:0] gate_sh;
  logic              cont_sh;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              sat_flag, sat_nxt;
  logic [GATE_W-1:0] remaining;
  logic [NCH-1:0]    vco_rise;
  logic              ref_rise;
  logic              vco_hit;
  logic              close_win;
  logic [SAT_W-1:0]  cnt_sat;

  // ---- input sampling: asynchronous pins into the clk domain ----
  for (genvar g = 0; g < NCH; g++) begin : g_vco_sync
    fdc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (vco_in[g]),
      .rise (vco_rise[g])
    );
  end

  fdc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ref_in),
    .rise (ref_rise)
  );

  // ---- control: window state machine ----
  assign vco_hit   = vco_rise[ch_sh];
  assign close_win = ref_rise && (remaining == GATE_W'(1));

  // State register; reset and abort both land in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     if (ref_rise) state_nxt = COUNT;
      COUNT:   if (close_win) state_nxt = DONE;
      DONE:    state_nxt = cont_sh ? COUNT : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
    end
  end

  assign load_sh      = (state == IDLE) && (state_nxt == ARM);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

  // ---- count datapath: saturating edge counter ----
  assign cnt_sat = sat_inc(SAT_W'(cnt), SAT_W'(CNT_MAX));

  // Count the selected edge; an unchanged increment means the counter is pinned.
  always_comb begin
    cnt_nxt = cnt;
    sat_nxt = sat_flag;
    if (vco_hit) begin
      cnt_nxt = cnt_sat[CNT_W-1:0];
      sat_nxt = sat_flag | (cnt_sat == SAT_W'(cnt));
    end
  end

  // Shadow capture at start, window counter and gate countdown.
  always_ff @(posedge clk) begin
    if (load_sh) begin
      ch_sh   <= (int'(ch_sel) < NCH) ? ch_sel : '0;
      gate_sh <= (gate_len == '0) ? GATE_W'(1) : gate_len;
      cont_sh <= cont;
    end
    case (state)
      ARM: begin
        if (ref_rise) begin
          cnt       <= '0;
          sat_flag  <= 1'b0;
          remaining <= gate_sh;
        end
      end
      COUNT: begin
        cnt      <= cnt_nxt;
        sat_flag <= sat_nxt;
        if (ref_rise) begin
          remaining <= remaining - GATE_W'(1);
        end
      end
      DONE: begin
        // The closing ref edge already opened the next window; an edge seen
        // now is its first count.
        cnt       <= CNT_W'(vco_hit);
        sat_flag  <= 1'b0;
        remaining <= gate_sh;
      end
      default: ;
    endcase
  end

  // ---- publish: result and overflow captured as the window closes ----
  // Loaded on the COUNT->DONE step so the closing-cycle edge is included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result   <= '0;
      overflow <= 1'b0;
    end else if ((state == COUNT) && (state_nxt == DONE)) begin
      result   <= cnt_nxt;
      overflow <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_fdc_meter.sv
// Randomised self-checking bench for fdc_meter. Pin edges are recorded with
// the clk edge at which the design can first act on them; expected counts
// are then derived from those timestamps.
module tb_fdc_meter;

  localparam int NCH    = 3;
  localparam int CNT_W  = 8;
  localparam int GATE_W = 8;
  localparam int SS     = 2;
  localparam int TCLK   = 10;
  // Pins toggle 3 ns before a clk rise; the design acts SS clocks later.
  localparam longint SEEN = 3 + SS * TCLK;
  localparam longint MAXC = (1 << CNT_W) - 1;

  typedef struct {
    int     ch;
    longint t;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              vco_pin [NCH];
  wire  [NCH-1:0]    vco_in;
  logic              ref_in;
  logic [1:0]        ch_sel;
  logic [GATE_W-1:0] gate_len;
  logic              cont;
  logic              start;
  logic              abort;
  logic              busy;
  logic [CNT_W-1:0]  result;
  logic              result_valid;
  logic              overflow;

  int     vco_per [NCH] = '{10, 20, 10};
  int     ref_per       = 100;
  ev_t    vq[$];
  longint rq[$];
  int     n_chk  = 0;
  int     n_fail = 0;
  int     vcount = 0;

  always #5 clk = ~clk;

  fdc_meter #(
    .NCH(NCH), .CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vco_in(vco_in), .ref_in(ref_in),
    .ch_sel(ch_sel), .gate_len(gate_len), .cont(cont), .start(start),
    .abort(abort), .busy(busy), .result(result),
    .result_valid(result_valid), .overflow(overflow)
  );

  for (genvar g = 0; g < NCH; g++) begin : g_vco_gen
    assign vco_in[g] = vco_pin[g];
    initial begin
      ev_t e;
      int  p;
      vco_pin[g] = 1'b0;
      #2;
      forever begin
        p = vco_per[g];
        vco_pin[g] = 1'b1;
        e.ch = g;
        e.t  = $time + SEEN;
        vq.push_back(e);
        #(p / 2 * TCLK);
        vco_pin[g] = 1'b0;
        #((p - p / 2) * TCLK);
      end
    end
  end

  initial begin
    int p;
    ref_in = 1'b0;
    #2;
    forever begin
      p = ref_per;
      ref_in = 1'b1;
      rq.push_back($time + SEEN);
      #(p / 2 * TCLK);
      ref_in = 1'b0;
      #((p - p / 2) * TCLK);
    end
  end

  always @(negedge clk) if (result_valid) vcount++;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Index of the first ref edge the design can see while in ARM.
  function automatic int find_open(input longint es);
    foreach (rq[i]) if (rq[i] >= es + TCLK) return i;
    return -1;
  endfunction

  function automatic int count_edges(input int ch, input longint lo, input longint hi);
    int n = 0;
    foreach (vq[i]) if (vq[i].ch == ch && vq[i].t > lo && vq[i].t <= hi) n++;
    return n;
  endfunction

  task automatic do_start(input int sel, input int glen, input bit c, output longint es);
    @(negedge clk);
    ch_sel   = 2'(sel);
    gate_len = GATE_W'(glen);
    cont     = c;
    start    = 1'b1;
    @(posedge clk);
    es = $time;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit got, output longint tv);
    got = 1'b0;
    tv  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (result_valid) begin
        got = 1'b1;
        tv  = $time;
        break;
      end
    end
  endtask

  // Window opens at rq[oi] (exclusive) and closes n ref edges later (inclusive).
  task automatic check_window(input string tag, input int ch, input int oi,
                              input int n, input bit got, input longint tv);
    longint close_t;
    int     ne;
    check_eq({tag, "_valid_seen"}, longint'(got), 1);
    if (!got) return;
    check_eq({tag, "_ref_edges"}, longint'(oi >= 0 && oi + n < rq.size()), 1);
    if (!(oi >= 0 && oi + n < rq.size())) return;
    close_t = rq[oi + n];
    ne = count_edges(ch, rq[oi], close_t);
    check_eq({tag, "_latency"}, tv - 5, close_t);
    check_eq({tag, "_result"}, longint'(result), (ne > MAXC) ? MAXC : longint'(ne));
    check_eq({tag, "_overflow"}, longint'(overflow), longint'(ne > MAXC));
  endtask

  initial begin
    longint es, tv;
    bit     got;
    int     oi, v0, sel, glen, ch;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0;
    ch_sel = '0; gate_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_valid", result_valid, 0);
    check_eq("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Basic count; vco0 and ref rises coincide, so the closing edge is shared.
    v0 = vcount;
    do_start(0, 4, 1'b0, es);
    check_eq("basic_busy", busy, 1);
    wait_valid(4000, got, tv);
    check_window("basic", 0, find_open(es), 4, got, tv);
    check_eq("basic_40", result, 40);
    @(negedge clk);
    check_eq("basic_busy_fall", busy, 0);
    repeat (50) @(negedge clk);
    check_eq("basic_one_valid", vcount - v0, 1);

    // Channel 1 with gate_len 0 (one ref period).
    do_start(1, 0, 1'b0, es);
    wait_valid(4000, got, tv);
    check_window("gate0", 1, find_open(es), 1, got, tv);
    check_eq("gate0_5", result, 5);

    // Saturation, then a normal run clears overflow.
    vco_per[0] = 4; ref_per = 200;
    repeat (250) @(negedge clk);
    do_start(0, 6, 1'b0, es);
    wait_valid(4000, got, tv);
    check_window("sat", 0, find_open(es), 6, got, tv);
    check_eq("sat_max", result, MAXC);
    check_eq("sat_ovf", overflow, 1);
    vco_per[0] = 40;
    repeat (250) @(negedge clk);
    do_start(0, 6, 1'b0, es);
    wait_valid(4000, got, tv);
    check_window("unsat", 0, find_open(es), 6, got, tv);
    check_eq("unsat_ovf", overflow, 0);

    // Continuous: frozen shadows, cont drop and restart ignored, then abort.
    vco_per[0] = 10; ref_per = 100;
    repeat (250) @(negedge clk);
    do_start(0, 2, 1'b1, es);
    oi = find_open(es);
    for (int w = 0; w < 3; w++) begin
      wait_valid(4000, got, tv);
      if (w == 0) oi = find_open(es);
      check_window($sformatf("cont%0d", w), 0, oi, 2, got, tv);
      check_eq($sformatf("cont%0d_20", w), result, 20);
      oi += 2;
      if (w == 0) begin
        cont = 1'b0; ch_sel = 2'd1; gate_len = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    v0 = vcount;
    repeat (300) @(negedge clk);
    check_eq("abort_no_valid", vcount - v0, 0);
    check_eq("abort_result_kept", result, 20);

    // Randomised runs, with a start pulse while busy on some of them.
    for (int r = 0; r < 6; r++) begin
      ref_per = $urandom_range(60, 150);
      for (int c = 0; c < NCH; c++) vco_per[c] = $urandom_range(6, 40);
      sel  = $urandom_range(0, 3);
      glen = $urandom_range(0, 3);
      ch   = (sel < NCH) ? sel : 0;
      repeat (30) @(negedge clk);
      do_start(sel, glen, 1'b0, es);
      if (r % 2 == 1) begin
        repeat (4) @(negedge clk);
        ch_sel = 2'(sel + 1); gate_len = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_valid(4000, got, tv);
      check_window($sformatf("rand%0d", r), ch, find_open(es), (glen == 0) ? 1 : glen, got, tv);
      @(negedge clk);
      check_eq($sformatf("rand%0d_idle", r), busy, 0);
    end

    // Reset behaviour: a glitch between edges is ignored, a sampled low is not.
    vco_per[0] = 10; ref_per = 100;
    repeat (250) @(negedge clk);
    do_start(0, 4, 1'b0, es);
    repeat (150) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #5 rst_n = 1'b1;
    @(negedge clk);
    check_eq("glitch_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_result", result, 0);
    check_eq("midrst_overflow", overflow, 0);
    check_eq("midrst_valid", result_valid, 0);
    rst_n = 1'b1;
    v0 = vcount;
    repeat (600) @(negedge clk);
    check_eq("midrst_no_valid", vcount - v0, 0);
    check_eq("midrst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
